// File: rtl/seq_match_prog.sv
// -----------------------------------------------------------------------------
// seq_match_prog
//
// Runtime-programmable serial pattern detector. A PAT_LEN-bit window of the
// incoming bit stream is compared against a loadable pattern. A per-bit care
// mask marks don't-care positions, and overlap mode selects whether a match
// may share bits with the next one. A match produces a registered one-cycle
// pulse on q and bumps a saturating match counter.
//
// Reset configuration detects "110x" with overlap enabled.
//
// Bit order: pat[PAT_LEN-1] is the first bit received and pat[0] the last.
// hist[0] always holds the newest bit.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset (highest priority)
//   in         in   1        serial data bit
//   en         in   1        bit valid; `in` is consumed only when en=1
//   cfg_we     in   1        load cfg_pat/cfg_care/cfg_ovl, clear the window
//   cfg_pat    in   PAT_LEN  new pattern
//   cfg_care   in   PAT_LEN  new care mask (1 = compare)
//   cfg_ovl    in   1        new overlap mode
//   cnt_clr    in   1        clear the match counter
//   q          out  1        registered match pulse
//   match_cnt  out  CNT_W    saturating match count
//
// Handshake: there is no back-pressure. A bit is consumed on every rising
// edge where en=1 and cfg_we=0; q is a valid-style pulse with no ready.
// -----------------------------------------------------------------------------
module seq_match_prog #(
    parameter int                 PAT_LEN  = 4,
    parameter int                 CNT_W    = 8,
    parameter logic [PAT_LEN-1:0] RST_PAT  = 4'b1100,
    parameter logic [PAT_LEN-1:0] RST_CARE = 4'b1110,
    parameter logic               RST_OVL  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               en,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pat,
    input  logic [PAT_LEN-1:0] cfg_care,
    input  logic               cfg_ovl,
    input  logic               cnt_clr,
    output logic               q,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int               FW      = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FULL    = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] care_q, care_d;
    logic               ovl_q, ovl_d;
    logic               q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               consume;
    logic [PAT_LEN-1:0] hist_sh;
    logic [FW-1:0]      fill_inc;
    logic               match;

    // A configuration write wins over a same-cycle data bit.
    assign consume  = en & ~cfg_we;
    assign hist_sh  = {hist_q[PAT_LEN-2:0], in};
    assign fill_inc = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    assign match    = consume && (fill_inc == FULL) &&
                      (((hist_sh ^ pat_q) & care_q) == '0);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        care_d = care_q;
        ovl_d  = ovl_q;
        q_d    = 1'b0;
        cnt_d  = cnt_q;

        if (cfg_we) begin
            pat_d  = cfg_pat;
            care_d = cfg_care;
            ovl_d  = cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_sh;
            // Non-overlap mode restarts the fill so the next match needs a
            // completely fresh window.
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
            q_d    = match;
        end

        // A same-cycle match survives the clear as a count of one.
        if (cnt_clr) begin
            cnt_d = match ? CNT_W'(1) : '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= RST_PAT;
            care_q <= RST_CARE;
            ovl_q  <= RST_OVL;
            q_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            care_q <= care_d;
            ovl_q  <= ovl_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q         = q_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_match_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_match_prog
//
// Three instances share clk/rst:
//   u_a : default parameters (PAT_LEN=4, CNT_W=8, reset pattern 110x)
//   u_b : CNT_W=2 for counter saturation
//   u_c : PAT_LEN=7, reset pattern 1011001 with full care
// Drivers push the expected {q, match_cnt} for the cycle after each drive;
// per-instance monitors pop and compare on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_match_prog;

    logic clk;
    logic rst;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A ----------------
    logic       a_in, a_en, a_we, a_ovl, a_clr, a_q;
    logic [3:0] a_pat, a_care;
    logic [7:0] a_cnt;

    seq_match_prog u_a (
        .clk(clk), .rst(rst), .in(a_in), .en(a_en), .cfg_we(a_we),
        .cfg_pat(a_pat), .cfg_care(a_care), .cfg_ovl(a_ovl),
        .cnt_clr(a_clr), .q(a_q), .match_cnt(a_cnt)
    );

    // ---------------- instance B ----------------
    logic       b_in, b_en, b_we, b_ovl, b_clr, b_q;
    logic [3:0] b_pat, b_care;
    logic [1:0] b_cnt;

    seq_match_prog #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in(b_in), .en(b_en), .cfg_we(b_we),
        .cfg_pat(b_pat), .cfg_care(b_care), .cfg_ovl(b_ovl),
        .cnt_clr(b_clr), .q(b_q), .match_cnt(b_cnt)
    );

    // ---------------- instance C ----------------
    logic       c_in, c_en, c_we, c_ovl, c_clr, c_q;
    logic [6:0] c_pat, c_care;
    logic [7:0] c_cnt;

    seq_match_prog #(
        .PAT_LEN(7), .CNT_W(8),
        .RST_PAT(7'b1011001), .RST_CARE(7'h7F), .RST_OVL(1'b1)
    ) u_c (
        .clk(clk), .rst(rst), .in(c_in), .en(c_en), .cfg_we(c_we),
        .cfg_pat(c_pat), .cfg_care(c_care), .cfg_ovl(c_ovl),
        .cnt_clr(c_clr), .q(c_q), .match_cnt(c_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_a[$];
    logic [2:0] exp_b[$];
    logic [8:0] exp_c[$];
    int         checks = 0;
    int         errors = 0;
    string      tname  = "init";

    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            checks++;
            if ({a_q, a_cnt} !== e) begin
                errors++;
                $display("FAIL %s a: got q=%0b cnt=%0d exp q=%0b cnt=%0d",
                         tname, a_q, a_cnt, e[8], e[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            checks++;
            if ({b_q, b_cnt} !== e) begin
                errors++;
                $display("FAIL %s b: got q=%0b cnt=%0d exp q=%0b cnt=%0d",
                         tname, b_q, b_cnt, e[2], e[1:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_c.size() > 0) begin
            e = exp_c.pop_front();
            checks++;
            if ({c_q, c_cnt} !== e) begin
                errors++;
                $display("FAIL %s c: got q=%0b cnt=%0d exp q=%0b cnt=%0d",
                         tname, c_q, c_cnt, e[8], e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_a(input logic rst_v, input logic we, input logic clr,
                           input logic en_v, input logic in_v,
                           input logic [3:0] pat, input logic [3:0] care,
                           input logic ovl, input logic eq, input logic [7:0] ecnt);
        rst = rst_v; a_we = we; a_clr = clr; a_en = en_v; a_in = in_v;
        a_pat = pat; a_care = care; a_ovl = ovl;
        @(posedge clk);
        #1;
        exp_a.push_back({eq, ecnt});
        rst = 1'b0; a_we = 1'b0; a_clr = 1'b0; a_en = 1'b0;
    endtask

    // Consume n bits (MSB first); qexp marks the bits expected to match and
    // the count advances by one at each of them.
    task automatic run_a(input int n, input logic [15:0] bits,
                         input logic [15:0] qexp, input logic [7:0] cnt0);
        logic [7:0] cnt;
        cnt = cnt0;
        for (int i = n - 1; i >= 0; i--) begin
            if (qexp[i]) cnt = cnt + 8'd1;
            drive_a(1'b0, 1'b0, 1'b0, 1'b1, bits[i], 4'h0, 4'h0, 1'b0, qexp[i], cnt);
        end
    endtask

    task automatic drive_b(input logic we, input logic clr, input logic en_v,
                           input logic in_v, input logic [3:0] care,
                           input logic ovl, input logic eq, input logic [1:0] ecnt);
        b_we = we; b_clr = clr; b_en = en_v; b_in = in_v;
        b_pat = 4'b0110; b_care = care; b_ovl = ovl;
        @(posedge clk);
        #1;
        exp_b.push_back({eq, ecnt});
        b_we = 1'b0; b_clr = 1'b0; b_en = 1'b0;
    endtask

    task automatic drive_c(input logic en_v, input logic in_v,
                           input logic eq, input logic [7:0] ecnt);
        c_en = en_v; c_in = in_v;
        @(posedge clk);
        #1;
        exp_c.push_back({eq, ecnt});
        c_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  p4;
        logic [6:0]  p7;
        logic [12:0] o13;
        logic [6:0]  win;
        int          fill_m;
        logic [7:0]  cnt_m;
        logic        m, en_v, bv;
        logic [1:0]  bcnt;

        rst = 1'b1;
        a_in = 0; a_en = 0; a_we = 0; a_ovl = 0; a_clr = 0; a_pat = 0; a_care = 0;
        b_in = 0; b_en = 0; b_we = 0; b_ovl = 0; b_clr = 0; b_pat = 0; b_care = 0;
        c_in = 0; c_en = 0; c_we = 0; c_ovl = 0; c_clr = 0; c_pat = 0; c_care = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state of every instance.
        tname = "reset";
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
        drive_c(1'b0, 1'b0, 1'b0, 8'd0);

        // Default 110x, overlap: matches on 1100 and 1101.
        tname = "default_110x";
        run_a(8, 16'b11001101, 16'b00010001, 8'd0);
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 8'd2);

        // 1010 with overlap, counter cleared in the config cycle.
        tname = "ovl1_1010";
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1010, 4'hF, 1'b1, 1'b0, 8'd0);
        run_a(6, 16'b101010, 16'b000101, 8'd0);

        // Same stream without overlap: only the first window matches.
        tname = "ovl0_1010";
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'hF, 1'b0, 1'b0, 8'd2);
        run_a(6, 16'b101010, 16'b000100, 8'd2);

        // en gaps: idle cycles carry the opposite bit, which must be ignored.
        tname = "en_gaps";
        drive_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 4'hF, 1'b1, 1'b0, 8'd0);
        p4 = 4'b1100;
        for (int i = 3; i >= 0; i--) begin
            drive_a(1'b0, 1'b0, 1'b0, 1'b1, p4[i], 4'h0, 4'h0, 1'b0,
                    (i == 0), (i == 0) ? 8'd1 : 8'd0);
            for (int k = 0; k < 2; k++)
                drive_a(1'b0, 1'b0, 1'b0, 1'b0, ~p4[i], 4'h0, 4'h0, 1'b0,
                        1'b0, (i == 0) ? 8'd1 : 8'd0);
        end

        // Reset mid-sequence aborts the partial match (rst beats en).
        tname = "rst_abort";
        run_a(3, 16'b110, 16'b000, 8'd1);
        drive_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
        run_a(1, 16'b0, 16'b0, 8'd0);

        // cfg_we mid-sequence clears the window and drops the same-cycle bit.
        tname = "cfg_abort";
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 4'hF, 1'b1, 1'b0, 8'd0);
        run_a(3, 16'b110, 16'b000, 8'd0);
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100, 4'hF, 1'b1, 1'b0, 8'd0);
        run_a(1, 16'b0, 16'b0, 8'd0);
        tname = "cfg_discard";
        drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 4'hF, 1'b1, 1'b0, 8'd0);
        run_a(3, 16'b100, 16'b000, 8'd0);
        run_a(4, 16'b1100, 16'b0001, 8'd0);

        // Counter saturation with care=0 on the 2-bit counter.
        tname = "sat";
        drive_b(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0);
        bcnt = 2'd0;
        for (int i = 0; i < 7; i++) begin
            if (i >= 3 && bcnt != 2'd3) bcnt = bcnt + 2'd1;
            drive_b(1'b0, 1'b0, 1'b1, i[0], 4'h0, 1'b1, (i >= 3), bcnt);
        end
        tname = "clr_with_match";
        drive_b(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 2'd1);
        tname = "clr_alone";
        drive_b(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'd0);

        // care=0 without overlap: one match per 4 bits.
        tname = "care0_ovl0";
        drive_b(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
        bcnt = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 7) bcnt = bcnt + 2'd1;
            drive_b(1'b0, 1'b0, 1'b1, ~i[1], 4'h0, 1'b0, (i == 3 || i == 7), bcnt);
        end

        // PAT_LEN=7: random stream with two inserted regions (a single match
        // and an overlapping double match) against a window-compare model.
        tname = "len7_random";
        p7  = 7'b1011001;
        o13 = 13'b1011001011001;
        win = '0;
        fill_m = 0;
        cnt_m = 8'd0;
        for (int i = 0; i < 220; i++) begin
            if (i >= 60 && i < 67) begin
                en_v = 1'b1; bv = p7[66 - i];
            end else if (i >= 140 && i < 153) begin
                en_v = 1'b1; bv = o13[152 - i];
            end else begin
                en_v = ($urandom_range(0, 9) != 0);
                bv   = 1'($urandom_range(0, 1));
            end
            m = 1'b0;
            if (en_v) begin
                win = {win[5:0], bv};
                if (fill_m < 7) fill_m++;
                m = (fill_m == 7) && (win == p7);
                if (m && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
            end
            drive_c(en_v, bv, m, cnt_m);
        end

        tname = "drain";
        repeat (2) @(posedge clk);
        checks++;
        if (exp_a.size() + exp_b.size() + exp_c.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0",
                     exp_a.size() + exp_b.size() + exp_c.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
